// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic MST_CPU  = 1'b0;
  localparam logic MST_LOAD = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational 2-way request selector: round-robin or fixed priority to master 0.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = MST_CPU;
    if (req == 2'b11) begin
      winner = (RR_EN != 0) ? ~last_grant : MST_CPU;
    end else if (req[1]) begin
      winner = MST_LOAD;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two masters onto one RAM port, sequences the access over MEM_LAT
// cycles and returns read data with a one-cycle done pulse.
//
// state     | meaning
// ST_IDLE   | no owner; requests sampled here
// ST_ACCESS | strobes driven for MEM_LAT cycles, down-counter running
// ST_DONE   | owner's done pulse; strobes off, gnt still held
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 1,
  parameter int RR_EN   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              last_grant;
  logic              owner;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              pick_valid, pick_winner;

  arb_pick #(.RR_EN(RR_EN)) u_pick (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (pick_valid) state_nxt = ST_ACCESS;
      ST_ACCESS: if (cnt == '0) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= '0;
      last_grant <= MST_LOAD;
      owner      <= MST_CPU;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            owner      <= pick_winner;
            last_grant <= pick_winner;
            lat_we     <= pick_winner ? m1_we    : m0_we;
            lat_addr   <= pick_winner ? m1_addr  : m0_addr;
            lat_wdata  <= pick_winner ? m1_wdata : m0_wdata;
            cnt        <= LAT_M1;
          end
        end
        ST_ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!lat_we) begin
            // RAM data is valid on the last access cycle
            if (owner == MST_LOAD) rdata1 <= mem_rdata;
            else                   rdata0 <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign m0_gnt    = (state != ST_IDLE) && (owner == MST_CPU);
  assign m1_gnt    = (state != ST_IDLE) && (owner == MST_LOAD);
  assign m0_done   = (state == ST_DONE) && (owner == MST_CPU);
  assign m1_done   = (state == ST_DONE) && (owner == MST_LOAD);
  assign m0_rdata  = rdata0;
  assign m1_rdata  = rdata1;
  assign mem_re    = (state == ST_ACCESS) && !lat_we;
  assign mem_we    = (state == ST_ACCESS) && lat_we;
  assign mem_addr  = (state == ST_ACCESS) ? lat_addr  : '0;
  assign mem_wdata = (state == ST_ACCESS) ? lat_wdata : '0;

endmodule
